boot_loader_ctrl: RTL and testbench
===================================

# boot_loader_ctrl

Sequencing controller that owns the shared MIPS memory bus during boot. After reset it holds the CPU in reset, streams a program image from a valid/ready word source into Memory through the CS/WE/address/data bus, then hands the bus to the CPU and releases it from reset. It sits between the MIPS core, the Memory block and the image source, and replaces ad-hoc testbench muxing of the memory bus.

## Interface
- ADDR_W, 32, memory address width (word addresses)
- DATA_W, 32, memory data width
- RST_HOLD, 4, cycles cpu_rst stays high after the bus is handed to the CPU (≥1)
- TIMEOUT, 256, consecutive LOAD cycles with s_valid low before abort (≥1)
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load
- base_addr  in  ADDR_W  first word address; latched on accepted start
- num_words  in  16  words to load; latched on accepted start
- s_valid  in  1  source word available
- s_data  in  DATA_W  source word
- s_ready  out  1  controller accepts a word this cycle
- cpu_cs, cpu_we  in  1  CPU bus strobes
- cpu_addr  in  ADDR_W  CPU bus address
- mem_cs, mem_we  out  1  strobes to Memory
- mem_addr  out  ADDR_W  address to Memory
- mem_wdata  out  DATA_W  write data to Memory
- mem_wdata_oe  out  1  high only while the controller drives the data bus
- cpu_rst  out  1  active-high reset to the CPU
- busy  out  1  high in LOAD/WRITE
- done  out  1  high in RUN
- err  out  1  high in ERROR

## Operation
- States: IDLE, LOAD, WRITE, RELEASE, RUN, ERROR.
- IDLE: cpu_rst=1, loader owns bus, mem_cs=mem_we=0. start → latch base_addr/num_words, word index i=0; if num_words==0 → RELEASE, else → LOAD.
- LOAD: s_ready=1. s_valid&s_ready → capture s_data, mem_addr=base+i, → WRITE. s_valid low increments stall counter; reaching TIMEOUT → ERROR. Counter clears on every handshake and on entering LOAD.
- WRITE: s_ready=0, mem_cs=mem_we=mem_wdata_oe=1 for exactly one cycle; i increments. If i+1==num_words → RELEASE, else → LOAD.
- RELEASE: bus muxed to CPU; cpu_rst=1 for RST_HOLD cycles, then → RUN.
- RUN: cpu_rst=0, done=1, mem_cs/mem_we/mem_addr are combinational copies of cpu_*; mem_wdata_oe=0. start ignored.
- ERROR: cpu_rst=1, loader owns bus with strobes low, err=1. start restarts exactly as from IDLE (relatched parameters, err cleared on leaving).
- start in LOAD/WRITE/RELEASE/RUN is ignored.
- Address arithmetic: base_addr+i modulo 2^ADDR_W; wrap is silent, no error.
- RST asserted in any state (including mid-WRITE): immediate return to IDLE, all outputs to reset values; partially loaded image is abandoned.

## Timing
- Reset values: state IDLE, cpu_rst=1, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wdata_oe=0, s_ready=0, busy=0, done=0, err=0.
- Loader-side mem_* outputs and s_ready are registered; only the RUN/RELEASE passthrough is combinational.
- start sampled at edge k → LOAD (s_ready=1) from cycle k+1.
- Handshake at edge m → WRITE strobe during cycle m+1, Memory captures at edge m+2.
- Peak throughput 1 word / 2 cycles; N words with s_valid held high: 2N cycles from LOAD entry to RELEASE.
- RUN entered exactly RST_HOLD cycles after RELEASE entry; cpu_rst falls and done rises in the same cycle.

## Structure
- Shared package mips_pkg: state enum boot_state_t, ADDR_W/DATA_W defaults.
- One sub-module: boot_stall_timer (loadable up-counter, clear/enable inputs, terminal-count output), used for both the TIMEOUT stall count and the RST_HOLD count.

## Test plan
- Reset mid-load: RST low during WRITE of word 2 → next cycle cpu_rst=1, mem_cs=0, s_ready=0, state IDLE.
- Normal load: base_addr=0x40, num_words=3, s_valid always high, data A,B,C → writes (0x40,A),(0x41,B),(0x42,C) on cycles 2,4,6 after LOAD entry; done=1 RST_HOLD cycles after RELEASE.
- Backpressure: s_valid toggles 1,0,0,1 → each word written exactly once, never while s_valid low, no duplicate addresses.
- Zero-length: num_words=0 → no mem_we pulse, IDLE→RELEASE→RUN, done=1 after RST_HOLD cycles.
- Timeout: TIMEOUT=8, s_valid held low after start → err=1 on cycle 8 of LOAD, cpu_rst stays 1; new start with num_words=1 completes and clears err.
- Handover/wrap: base_addr=0xFFFFFFFF, num_words=2 → writes to 0xFFFFFFFF then 0x0; in RUN, cpu_cs=1/cpu_addr=0x10 appears on mem_cs/mem_addr same cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS-side types and bus width defaults for the boot path
package mips_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RELEASE, RUN, ERROR} boot_state_t;
endpackage

// File: rtl/boot_stall_timer.sv
// boot_stall_timer: up-counter with clear/enable; tc is high while the count sits at limit-1
// ports: clk, rst_n (async, active-low), clr (zero count, wins over en), en (count up), limit (terminal value), tc
module boot_stall_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign tc = cnt == limit - 1'b1;
endmodule

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: owns the memory bus at boot, streams an image into Memory, then hands the bus to the CPU
// ports: clk, rst_n (async, active-low); start/base_addr/num_words load request; s_valid/s_data/s_ready word source;
//        cpu_cs/cpu_we/cpu_addr CPU bus; mem_* Memory bus; cpu_rst CPU reset; busy/done/err status
module boot_loader_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RST_HOLD = 4,
    parameter int TIMEOUT  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_words,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = $clog2((TIMEOUT > RST_HOLD ? TIMEOUT : RST_HOLD) + 1);
    boot_state_t state, state_n;
    logic [ADDR_W-1:0] base_q, addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [15:0] n_q, i_q;
    logic s_ready_q, wr_q, hs, pass, t_clr, t_en, t_tc;
    assign hs = s_valid && s_ready_q;
    // one timer serves both the LOAD stall count and the RELEASE hold count
    boot_stall_timer #(.W(CW)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .clr(t_clr),
        .en(t_en),
        .limit(state == RELEASE ? CW'(RST_HOLD) : CW'(TIMEOUT)),
        .tc(t_tc)
    );
    always_comb begin
        state_n = state;
        t_clr = 1'b1;
        t_en = 1'b0;
        case (state)
            IDLE, ERROR: if (start) state_n = num_words == 16'd0 ? RELEASE : LOAD;
            LOAD: begin
                t_clr = hs;
                t_en = !s_valid;
                state_n = hs ? WRITE : t_tc ? ERROR : LOAD;
            end
            WRITE: state_n = i_q + 16'd1 == n_q ? RELEASE : LOAD;
            RELEASE: begin
                t_clr = 1'b0;
                t_en = 1'b1;
                if (t_tc) state_n = RUN;
            end
            default: state_n = state;
        endcase
    end
    // loader-side strobes are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            base_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            n_q <= '0;
            i_q <= '0;
            s_ready_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            state <= state_n;
            s_ready_q <= state_n == LOAD;
            wr_q <= state_n == WRITE;
            if ((state == IDLE || state == ERROR) && start) begin
                base_q <= base_addr;
                n_q <= num_words;
                i_q <= '0;
            end
            if (hs) begin
                addr_q <= base_q + ADDR_W'(i_q);
                wdata_q <= s_data;
            end
            if (state == WRITE) i_q <= i_q + 16'd1;
        end
    assign pass = state == RELEASE || state == RUN;
    assign mem_cs = pass ? cpu_cs : wr_q;
    assign mem_we = pass ? cpu_we : wr_q;
    assign mem_addr = pass ? cpu_addr : addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wdata_oe = wr_q;
    assign s_ready = s_ready_q;
    assign cpu_rst = state != RUN;
    assign busy = state == LOAD || state == WRITE;
    assign done = state == RUN;
    assign err = state == ERROR;
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl: randomized self-checking bench with a queue-based model of expected memory writes
module tb_boot_loader_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RH = 4;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_ready;
    logic cpu_cs = 1'b0;
    logic cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic mem_cs, mem_we, mem_wdata_oe, cpu_rst, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [AW-1:0] wa[$], ea[$];
    logic [DW-1:0] wd[$], ed[$];
    int wc[$];
    logic exp_err;

    boot_loader_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RST_HOLD(RH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wdata_oe(mem_wdata_oe), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (mem_we && mem_wdata_oe) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    // mode 0: valid always, 1: valid pattern 1,0,0,1, 2: random valid, 3: valid never
    task automatic do_load(input logic [AW-1:0] base, input int n, input int mode,
                           output int l_cyc, output int end_cyc, output logic first_rdy);
        int k = 0;
        int ph = 0;
        int stall = 0;
        logic [DW-1:0] w;
        wa.delete(); wd.delete(); wc.delete(); ea.delete(); ed.delete();
        exp_err = 1'b0;
        base_addr = base;
        num_words = 16'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
        l_cyc = cyc;
        first_rdy = s_ready;
        end_cyc = -1;
        w = $urandom;
        for (int c = 0; c < 2000 && end_cyc < 0; c++) begin
            s_data = w;
            s_valid = (mode == 0) || (mode == 1 && (ph % 4 == 0 || ph % 4 == 3)) ||
                      (mode == 2 && $urandom_range(0, 3) != 0);
            if (s_ready && s_valid) begin
                ea.push_back(base + AW'(k));
                ed.push_back(w);
                k++;
                w = $urandom;
                stall = 0;
            end else if (s_ready) begin
                stall++;
                if (stall == TO) exp_err = 1'b1;
            end
            if (s_ready) ph++;
            tick;
            if (done || err) end_cyc = cyc;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        checks++;
        if ({cpu_rst, mem_cs, mem_we, mem_wdata_oe, s_ready, busy, done, err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 10000000", {cpu_rst, mem_cs, mem_we, mem_wdata_oe, s_ready, busy, done, err});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr %0h data %0h expected 0 0", mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        tick;
        tick;
        checks++;
        if ({cpu_rst, s_ready, busy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_hold: got %b expected 1000", {cpu_rst, s_ready, busy, done});
        end
    endtask

    task automatic test_normal;
        int l, e;
        logic r;
        do_reset;
        do_load(32'h40, 3, 0, l, e, r);
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL normal_first_ready: got %b expected 1", r); end
        checks++;
        if (wa.size() != 3) begin errors++; $display("FAIL normal_count: got %0d expected 3", wa.size()); end
        for (int j = 0; j < 3 && j < wa.size(); j++) begin
            checks++;
            if (wa[j] !== 32'h40 + AW'(j) || wd[j] !== ed[j] || wc[j] != l + 1 + 2 * j) begin
                errors++;
                $display("FAIL normal_write%0d: got (%0h,%0h,@%0d) expected (%0h,%0h,@%0d)", j, wa[j], wd[j], wc[j], 32'h40 + j, ed[j], l + 1 + 2 * j);
            end
        end
        checks++;
        if (e != l + 6 + RH || done !== 1'b1 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL normal_done: got cycle %0d done %b cpu_rst %b expected cycle %0d 1 0", e - l, done, cpu_rst, 6 + RH);
        end
    endtask

    task automatic test_reset_mid;
        logic [AW-1:0] b;
        b = $urandom;
        do_reset;
        wa.delete();
        base_addr = b;
        num_words = 16'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        s_valid = 1'b1;
        s_data = $urandom;
        tick;
        tick;
        tick;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== b + 1) begin
            errors++;
            $display("FAIL mid_write2: got we %b addr %0h expected 1 %0h", mem_we, mem_addr, b + 1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_rst, mem_cs, s_ready, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_reset: got %b expected 1000", {cpu_rst, mem_cs, s_ready, busy});
        end
        s_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) tick;
        checks++;
        if (wa.size() != 1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_abandon: got writes %0d busy %b expected 1 0", wa.size(), busy);
        end
    endtask

    task automatic test_backpressure;
        int l, e;
        logic r;
        do_reset;
        do_load($urandom, 4, 1, l, e, r);
        checks++;
        if (wa.size() != 4 || ea.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 4", wa.size());
        end
        for (int j = 0; j < 4 && j < wa.size() && j < ea.size(); j++) begin
            checks++;
            if (wa[j] !== ea[j] || wd[j] !== ed[j]) begin
                errors++;
                $display("FAIL bp_write%0d: got (%0h,%0h) expected (%0h,%0h)", j, wa[j], wd[j], ea[j], ed[j]);
            end
        end
        checks++;
        if (e < 0 || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: got done %b err %b expected 1 0", done, err);
        end
    endtask

    task automatic test_zero_len;
        int l, e;
        logic r;
        do_reset;
        do_load($urandom, 0, 0, l, e, r);
        checks++;
        if (wa.size() != 0 || r !== 1'b0) begin
            errors++;
            $display("FAIL zero_writes: got %0d ready %b expected 0 0", wa.size(), r);
        end
        checks++;
        if (e != l + RH || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got cycle %0d expected %0d", e - l, RH);
        end
    endtask

    task automatic test_timeout;
        int l, e;
        logic r;
        do_reset;
        do_load($urandom, 3, 3, l, e, r);
        checks++;
        if (err !== exp_err || e != l + TO) begin
            errors++;
            $display("FAIL timeout_err: got err %b at %0d expected %b at %0d", err, e - l, exp_err, TO);
        end
        checks++;
        if ({cpu_rst, busy, s_ready, mem_cs, done} !== 5'b10000 || wa.size() != 0) begin
            errors++;
            $display("FAIL timeout_bus: got %b writes %0d expected 10000 0", {cpu_rst, busy, s_ready, mem_cs, done}, wa.size());
        end
        do_load($urandom, 1, 0, l, e, r);
        checks++;
        if (err !== 1'b0 || done !== 1'b1 || e != l + 2 + RH) begin
            errors++;
            $display("FAIL timeout_restart: got err %b done %b at %0d expected 0 1 at %0d", err, done, e - l, 2 + RH);
        end
        checks++;
        if (wa.size() != 1 || wa[0] !== ea[0] || wd[0] !== ed[0]) begin
            errors++;
            $display("FAIL timeout_rewrite: got %0d writes expected 1 to %0h", wa.size(), ea[0]);
        end
    endtask

    task automatic test_wrap_handover;
        int l, e;
        logic r;
        logic [AW-1:0] a;
        do_reset;
        do_load(32'hFFFF_FFFF, 2, 0, l, e, r);
        checks++;
        if (wa.size() != 2 || wa[0] !== 32'hFFFF_FFFF || wa[1] !== 32'h0 || wd[1] !== ed[1]) begin
            errors++;
            $display("FAIL wrap_addr: got %0d writes first %0h expected 2 ffffffff then 0", wa.size(), wa[0]);
        end
        cpu_cs = 1'b1;
        cpu_addr = 32'h10;
        #1;
        checks++;
        if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || mem_wdata_oe !== 1'b0) begin
            errors++;
            $display("FAIL handover_rd: got cs %b we %b addr %0h oe %b expected 1 0 10 0", mem_cs, mem_we, mem_addr, mem_wdata_oe);
        end
        a = $urandom;
        cpu_we = 1'b1;
        cpu_addr = a;
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== a) begin
            errors++;
            $display("FAIL handover_wr: got we %b addr %0h expected 1 %0h", mem_we, mem_addr, a);
        end
        cpu_cs = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic test_ignore_start;
        wa.delete();
        base_addr = $urandom;
        num_words = 16'd3;
        start = 1'b1;
        s_valid = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 6; c++) tick;
        s_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || s_ready !== 1'b0 || wa.size() != 0) begin
            errors++;
            $display("FAIL run_ignore_start: got done %b rst %b ready %b writes %0d expected 1 0 0 0", done, cpu_rst, s_ready, wa.size());
        end
    endtask

    task automatic test_random;
        int l, e, n;
        logic r;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 6);
            do_reset;
            do_load($urandom, n, 2, l, e, r);
            checks++;
            if (err !== exp_err || done === exp_err || wa.size() != ea.size()) begin
                errors++;
                $display("FAIL rand%0d_status: got err %b done %b writes %0d expected err %b writes %0d", it, err, done, wa.size(), exp_err, ea.size());
            end
            for (int j = 0; j < wa.size() && j < ea.size(); j++) begin
                checks++;
                if (wa[j] !== ea[j] || wd[j] !== ed[j]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: got (%0h,%0h) expected (%0h,%0h)", it, j, wa[j], wd[j], ea[j], ed[j]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_reset_mid;
        test_backpressure;
        test_zero_len;
        test_timeout;
        test_wrap_handover;
        test_ignore_start;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
